spi_master_param: RTL and testbench
===================================

SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per transfer; legal range 4..32.
REQ-002 Parameter NUM_CS, default 4, number of slave-select outputs; legal range 1..8.
REQ-003 Parameter DIV_WIDTH, default 8, width of the clk_div input.
REQ-004 clk  input  1  system clock; the single clock, all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 start  input  1  one-cycle transfer request; accepted only while busy=0.
REQ-007 cs_sel  input  max(1,$clog2(NUM_CS))  slave index, latched on start.
REQ-008 cpol, cpha, lsb_first  input  1 each  SPI mode and bit order, latched on start.
REQ-009 clk_div  input  DIV_WIDTH  half-period = clk_div+1 clk cycles, latched on start.
REQ-010 tx_data  input  DATA_WIDTH  word to transmit, latched on start.
REQ-011 rx_data  output  DATA_WIDTH  last received word.
REQ-012 busy  output  1  high from the cycle after an accepted start until done.
REQ-013 done  output  1  single-cycle completion pulse.
REQ-014 spi_sclk, spi_mosi  output  1 each  SPI clock and master data out.
REQ-015 spi_miso  input  1  slave data in, sampled synchronously to clk.
REQ-016 spi_ss_n  output  NUM_CS  active-low slave selects, at most one low.

Function
REQ-017 FSM states: IDLE, LEAD, XFER, TRAIL, DONE; each of LEAD and TRAIL lasts one half-period, and XFER lasts 2*DATA_WIDTH half-periods.
REQ-018 IDLE->LEAD on start with busy=0; LEAD->XFER->TRAIL on half-period expiry; TRAIL->DONE; DONE->IDLE (or ->LEAD if start is present in DONE).
REQ-019 busy is 0 in IDLE and DONE and 1 otherwise, so start in the DONE cycle is accepted (back-to-back transfer).
REQ-020 start while busy=1 is ignored, with no effect on the active transfer or the latched parameters.
REQ-021 spi_ss_n[cs_sel] is low from entry to LEAD through the end of TRAIL; all other bits stay high; if cs_sel>=NUM_CS, all bits stay high but the transfer still runs.
REQ-022 spi_sclk equals the latched cpol outside XFER and toggles at each half-period boundary inside XFER (2*DATA_WIDTH edges).
REQ-023 cpha=0: first bit driven on spi_mosi at LEAD entry; spi_miso sampled on leading edges; mosi shifted on trailing edges.
REQ-024 cpha=1: mosi shifted on leading edges (first bit on the first leading edge); spi_miso sampled on trailing edges.
REQ-025 lsb_first=0 transmits and receives MSB first; lsb_first=1 transmits and receives LSB first, and rx_data is assembled in the same bit order.
REQ-026 spi_mosi is 0 while in IDLE.
REQ-027 done goes high exactly (2*DATA_WIDTH+2)*(clk_div+1)+1 cycles after the cycle in which start was sampled.
REQ-028 rx_data updates only in the done cycle and holds until the next done.
REQ-029 clk_div=0 gives sclk = clk/2; the half-period counter reloads without a lost cycle.

Reset
REQ-030 reset=0 forces, asynchronously: state=IDLE, busy=0, done=0, rx_data=0, spi_ss_n=all 1, spi_mosi=0, spi_sclk=0, shift and counter registers=0.
REQ-031 reset asserted mid-transfer aborts the transfer immediately, with no done pulse and rx_data=0.
REQ-032 After reset is released, spi_sclk follows the cpol latched by the first accepted start.

Structure
REQ-033 Package spi_pkg holds the FSM state enumeration, the mode-encoding constants (MODE0..MODE3 as {cpol,cpha}) and the parameter defaults.
REQ-034 Sub-module spi_clk_div holds the half-period counter; its input is the latched clk_div, and it emits a one-cycle edge tick and a leading/trailing flag.
REQ-035 The top level contains the FSM, the shift registers and the slave-select decode.

Verification
REQ-036 Mode 0, DATA_WIDTH=8, clk_div=1, tx=0xA5, miso looped to mosi -> rx_data=0xA5, done at cycle 37, ss_n[0] low for 36 cycles.
REQ-037 Mode 3, lsb_first=1, tx=0x3C, slave model returns 0x81 LSB-first -> rx_data=0x81, spi_sclk idles high, and the mosi sequence is 0,0,1,1,1,1,0,0.
REQ-038 Back-to-back: start in the done cycle with cs_sel=2 -> second transfer begins next cycle, and ss_n goes 1110 -> 1111 -> 1011 with one idle cycle.
REQ-039 start pulsed mid-transfer with tx=0xFF -> ignored; the original tx shifts out and exactly one done pulse occurs.
REQ-040 reset dropped at XFER edge 5 -> spi_ss_n=all 1, busy=0, rx_data=0 immediately, and no done pulse.
REQ-041 clk_div=0, mode 1, tx=0x5A -> done at cycle 19, spi_sclk toggles every cycle during XFER, rx_data matches the slave word.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the parameterised SPI master: FSM states,
// SPI mode encodings ({cpol,cpha}) and parameter defaults.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_XFER,
    ST_TRAIL,
    ST_DONE
  } spi_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_CS     = 4;
  localparam int DEF_DIV_WIDTH  = 8;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer for the SPI master. Emits a one-cycle tick on the last
// clk cycle of every half-period while enabled, plus a flag telling whether
// the sclk edge made at that tick is a leading or a trailing edge.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 en_i,
  input  logic                 xfer_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o,
  output logic                 lead_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 phase_q, phase_d;

  // Count up to the latched divider; wrap to zero on the tick so that
  // div_i = 0 yields a tick every cycle with no lost reload cycle.
  always_comb begin
    tick_o  = en_i && (cnt_q == div_i);
    cnt_d   = '0;
    phase_d = 1'b0;
    if (en_i && !tick_o) begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
    if (xfer_i) begin
      phase_d = tick_o ? ~phase_q : phase_q;
    end
    lead_o = ~phase_q;
  end

  // Counter and edge-phase registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parameterised SPI master: one transfer of DATA_WIDTH bits per accepted
// start, all four SPI modes, selectable bit order and slave select.
module spi_master_param
  import spi_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int NUM_CS     = DEF_NUM_CS,
  parameter  int DIV_WIDTH  = DEF_DIV_WIDTH,
  localparam int CSW        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CSW-1:0]        cs_sel,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  spi_sclk,
  output logic                  spi_mosi,
  input  logic                  spi_miso,
  output logic [NUM_CS-1:0]     spi_ss_n
);

  localparam int ECW = $clog2(2 * DATA_WIDTH);

  spi_state_e            state_q;
  logic                  cpol_q, cpha_q, lsb_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [DATA_WIDTH-1:0] tx_q, rx_q, rx_data_q;
  logic [ECW-1:0]        edge_q;
  logic                  busy_q, done_q, sclk_q, mosi_q;
  logic [NUM_CS-1:0]     ss_n_q;

  logic                  tick, lead, sample_lead;
  logic [NUM_CS-1:0]     ss_dec;
  logic                  first_bit, tx_head;
  logic [DATA_WIDTH-1:0] tx_first, tx_next, rx_next;

  spi_clk_div #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clk_div (
    .clk_i    (clk),
    .reset_ni (reset),
    .en_i     (busy_q),
    .xfer_i   (state_q == ST_XFER),
    .div_i    (div_q),
    .tick_o   (tick),
    .lead_o   (lead)
  );

  // Slave-select decode of the requested index; out-of-range selects none.
  always_comb begin
    ss_dec = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (32'(cs_sel) == i) ss_dec[i] = 1'b0;
    end
  end

  // Edge role per mode, and bit-order dependent shift helpers.
  always_comb begin
    sample_lead = 1'b1;
    case ({cpol_q, cpha_q})
      MODE0, MODE2: sample_lead = 1'b1;
      MODE1, MODE3: sample_lead = 1'b0;
      default:      sample_lead = 1'b1;
    endcase
    first_bit = lsb_first ? tx_data[0] : tx_data[DATA_WIDTH-1];
    tx_first  = lsb_first ? {1'b0, tx_data[DATA_WIDTH-1:1]} : {tx_data[DATA_WIDTH-2:0], 1'b0};
    tx_head   = lsb_q ? tx_q[0] : tx_q[DATA_WIDTH-1];
    tx_next   = lsb_q ? {1'b0, tx_q[DATA_WIDTH-1:1]} : {tx_q[DATA_WIDTH-2:0], 1'b0};
    rx_next   = lsb_q ? {spi_miso, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], spi_miso};
  end

  // Transfer FSM with registered SPI pins, status and shift registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      div_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      edge_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss_n_q    <= '1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_LEAD;
            busy_q  <= 1'b1;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            lsb_q   <= lsb_first;
            div_q   <= clk_div;
            ss_n_q  <= ss_dec;
            sclk_q  <= cpol;
            edge_q  <= '0;
            rx_q    <= '0;
            // cpha=0 presents the first bit now; cpha=1 waits for the first leading edge.
            if (cpha) begin
              tx_q   <= tx_data;
              mosi_q <= 1'b0;
            end else begin
              tx_q   <= tx_first;
              mosi_q <= first_bit;
            end
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            mosi_q  <= 1'b0;
          end
        end
        ST_LEAD: begin
          if (tick) state_q <= ST_XFER;
        end
        ST_XFER: begin
          if (tick) begin
            sclk_q <= ~sclk_q;
            edge_q <= edge_q + ECW'(1);
            if (lead == sample_lead) begin
              rx_q <= rx_next;
            end else begin
              mosi_q <= tx_head;
              tx_q   <= tx_next;
            end
            if (edge_q == ECW'(2 * DATA_WIDTH - 1)) state_q <= ST_TRAIL;
          end
        end
        ST_TRAIL: begin
          if (tick) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            rx_data_q <= rx_q;
            ss_n_q    <= '1;
            mosi_q    <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_data  = rx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_ss_n = ss_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param (DATA_WIDTH=8, NUM_CS=4, DIV_WIDTH=8).
module tb_spi_master_param;

  localparam int DW  = 8;
  localparam int NCS = 4;
  localparam int DVW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    cs_sel;
  logic          cpol, cpha, lsb_first;
  logic [DVW-1:0] clk_div;
  logic [DW-1:0] tx_data, rx_data;
  logic          busy, done, spi_sclk, spi_mosi, spi_miso;
  logic [NCS-1:0] spi_ss_n;

  logic          loop_en, miso_r;
  assign spi_miso = loop_en ? spi_mosi : miso_r;

  spi_master_param #(
    .DATA_WIDTH (DW),
    .NUM_CS     (NCS),
    .DIV_WIDTH  (DVW)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start),
    .cs_sel    (cs_sel),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsb_first (lsb_first),
    .clk_div   (clk_div),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .busy      (busy),
    .done      (done),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .spi_ss_n  (spi_ss_n)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave / bus monitor: counts sclk edges, records mosi at the slave's
  // sample edges, and drives miso on leading edges for cpha=1 slaves.
  logic          tb_cpol = 1'b0, tb_cpha = 1'b0;
  logic [DW-1:0] slave_word = '0;
  logic          slave_lsb = 1'b0;
  int            edge_cnt = 0, first_edge = 0, last_edge = 0, sbit = 0;
  logic [DW-1:0] mosi_seq = '0;
  logic          sclk_prev = 1'b0, busy_prev = 1'b0;
  logic          is_lead;

  always @(negedge clk) begin
    if (busy && !busy_prev) begin
      edge_cnt = 0;
      mosi_seq = '0;
      sbit     = 0;
    end else if (busy && (spi_sclk != sclk_prev)) begin
      edge_cnt++;
      if (edge_cnt == 1) first_edge = cyc;
      last_edge = cyc;
      is_lead = (sclk_prev == tb_cpol);
      if (is_lead == !tb_cpha) mosi_seq = {mosi_seq[DW-2:0], spi_mosi};
      if (tb_cpha && is_lead && sbit < DW) begin
        miso_r = slave_lsb ? slave_word[sbit] : slave_word[DW-1-sbit];
        sbit++;
      end
    end
    sclk_prev = spi_sclk;
    busy_prev = busy;
  end

  task automatic kick(input logic [1:0] cs, input logic pol, input logic pha, input logic lsb,
                      input logic [DVW-1:0] div, input logic [DW-1:0] tx);
    cs_sel = cs; cpol = pol; cpha = pha; lsb_first = lsb; clk_div = div; tx_data = tx;
    tb_cpol = pol; tb_cpha = pha;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Observes cycles 1..ncyc after the start edge (caller is already #1 into cycle 1).
  task automatic observe(input int ncyc, input bit stop_on_done, input int inj,
                         output int done_cnt, output int first_done, output int ss_low,
                         output logic sclk1, output logic busy1,
                         output logic [3:0] ss_prev_done, output logic [3:0] ss_done);
    logic [3:0] ss_last;
    done_cnt = 0; first_done = -1; ss_low = 0; sclk1 = 1'b0; busy1 = 1'b0;
    ss_prev_done = '0; ss_done = '0; ss_last = spi_ss_n;
    for (int c = 1; c <= ncyc; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c == 1) begin sclk1 = spi_sclk; busy1 = busy; end
      if (inj != 0 && c == inj) begin
        start = 1'b1; tx_data = 'hFF; cs_sel = 2'd1; cpol = 1'b1; cpha = 1'b1;
        lsb_first = 1'b1; clk_div = 8'd3;
      end
      if (inj != 0 && c == inj + 1) start = 1'b0;
      if (spi_ss_n != 4'hF) ss_low++;
      if (done) begin
        done_cnt++;
        if (first_done < 0) begin
          first_done = c; ss_prev_done = ss_last; ss_done = spi_ss_n;
        end
        if (stop_on_done) break;
      end
      ss_last = spi_ss_n;
    end
  endtask

  int dc, fd, sl, w;
  logic s1, b1;
  logic [3:0] spd, sd;

  initial begin
    rst_n = 1'b0; start = 1'b0; cs_sel = '0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    clk_div = '0; tx_data = '0; loop_en = 1'b1; miso_r = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rx",   32'(rx_data), 0);
    chk("rst_ss",   32'(spi_ss_n), 'hF);
    chk("rst_mosi", 32'(spi_mosi), 0);
    chk("rst_sclk", 32'(spi_sclk), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Mode 3, LSB first, slave returns 0x81; first transfer after reset.
    loop_en = 1'b0; slave_word = 'h81; slave_lsb = 1'b1;
    kick(2'd0, 1'b1, 1'b1, 1'b1, 8'd2, 8'h3C);
    observe(80, 1'b1, 0, dc, fd, sl, s1, b1, spd, sd);
    chk("m3_sclk_lead", 32'(s1), 1);
    chk("m3_busy",      32'(b1), 1);
    chk("m3_done_cyc",  32'(fd), 55);
    chk("m3_rx",        32'(rx_data), 'h81);
    chk("m3_mosi_seq",  32'(mosi_seq), 'h3C);
    chk("m3_edges",     32'(edge_cnt), 16);
    chk("m3_sclk_done", 32'(spi_sclk), 1);
    @(posedge clk); #1;
    chk("m3_sclk_idle", 32'(spi_sclk), 1);
    chk("m3_done_1cyc", 32'(done), 0);
    chk("m3_busy_idle", 32'(busy), 0);

    // Mode 0, clk_div=1, loopback.
    loop_en = 1'b1;
    kick(2'd0, 1'b0, 1'b0, 1'b0, 8'd1, 8'hA5);
    observe(80, 1'b1, 0, dc, fd, sl, s1, b1, spd, sd);
    chk("m0_done_cyc", 32'(fd), 37);
    chk("m0_ss_low",   32'(sl), 36);
    chk("m0_ss_pat",   32'(spd), 'b1110);
    chk("m0_rx",       32'(rx_data), 'hA5);
    chk("m0_mosi_seq", 32'(mosi_seq), 'hA5);
    chk("m0_edges",    32'(edge_cnt), 16);
    @(posedge clk); #1;
    chk("m0_done_1cyc", 32'(done), 0);
    chk("m0_rx_hold",   32'(rx_data), 'hA5);

    // Back-to-back: second start issued in the done cycle.
    kick(2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h3C);
    observe(40, 1'b1, 0, dc, fd, sl, s1, b1, spd, sd);
    chk("b2b1_done_cyc", 32'(fd), 19);
    chk("b2b1_rx",       32'(rx_data), 'h3C);
    chk("b2b1_ss_prev",  32'(spd), 'b1110);
    chk("b2b1_ss_done",  32'(sd), 'b1111);
    kick(2'd2, 1'b0, 1'b0, 1'b0, 8'd0, 8'hC3);
    chk("b2b2_ss_next",  32'(spi_ss_n), 'b1011);
    chk("b2b2_busy",     32'(busy), 1);
    observe(40, 1'b1, 0, dc, fd, sl, s1, b1, spd, sd);
    chk("b2b2_done_cyc", 32'(fd), 19);
    chk("b2b2_rx",       32'(rx_data), 'hC3);
    chk("b2b2_ss_prev",  32'(spd), 'b1011);

    // Start pulsed mid-transfer is ignored.
    kick(2'd0, 1'b0, 1'b0, 1'b0, 8'd1, 8'h96);
    observe(70, 1'b0, 10, dc, fd, sl, s1, b1, spd, sd);
    chk("ign_done_cnt", 32'(dc), 1);
    chk("ign_done_cyc", 32'(fd), 37);
    chk("ign_rx",       32'(rx_data), 'h96);
    chk("ign_mosi_seq", 32'(mosi_seq), 'h96);
    chk("ign_ss_low",   32'(sl), 36);

    // Reset dropped at XFER edge 5.
    kick(2'd3, 1'b0, 1'b0, 1'b0, 8'd1, 8'hA5);
    chk("ar_ss_sel", 32'(spi_ss_n), 'b0111);
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (edge_cnt < 5 && w < 100);
    chk("ar_edge5", 32'(edge_cnt), 5);
    rst_n = 1'b0;
    #1;
    chk("ar_ss",   32'(spi_ss_n), 'hF);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_rx",   32'(rx_data), 0);
    chk("ar_done", 32'(done), 0);
    chk("ar_sclk", 32'(spi_sclk), 0);
    chk("ar_mosi", 32'(spi_mosi), 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    observe(60, 1'b0, 0, dc, fd, sl, s1, b1, spd, sd);
    chk("ar_no_done", 32'(dc), 0);
    chk("ar_ss_idle", 32'(sl), 0);

    // Mode 1, clk_div=0, slave returns 0xC6 MSB first.
    loop_en = 1'b0; slave_word = 'hC6; slave_lsb = 1'b0;
    kick(2'd1, 1'b0, 1'b1, 1'b0, 8'd0, 8'h5A);
    observe(40, 1'b1, 0, dc, fd, sl, s1, b1, spd, sd);
    chk("m1_done_cyc",  32'(fd), 19);
    chk("m1_rx",        32'(rx_data), 'hC6);
    chk("m1_mosi_seq",  32'(mosi_seq), 'h5A);
    chk("m1_edges",     32'(edge_cnt), 16);
    chk("m1_edge_span", 32'(last_edge - first_edge), 15);
    chk("m1_ss_pat",    32'(spd), 'b1101);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
